// File: rtl/i2s_rx_ctrl.sv
// I2S receive-path master: BCK/LRCK generation, fixed-slot word capture,
// truncation and block-framed valid/ready streaming toward the FFT buffer.
module i2s_rx_ctrl #(
    parameter int BCK_DIV   = 4,
    parameter int FRAME_RES = 32,
    parameter int DATA_RES  = 24,
    parameter int OUT_RES   = 16,
    parameter int N_SAMPLES = 256,
    parameter int CHANNEL   = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic                bck_o,
    output logic                lrck_o,
    input  logic [DATA_RES-1:0] left_i,
    input  logic [DATA_RES-1:0] right_i,
    output logic [OUT_RES-1:0]  sample_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                busy_o,
    output logic                overflow_o,
    input  logic                clr_ovf_i
);

    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * FRAME_RES);
    localparam int SMP_W = $clog2(N_SAMPLES);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(2 * FRAME_RES - 1);
    localparam logic [BIT_W-1:0] SLOT    = (CHANNEL == 0) ?
                                           BIT_W'(FRAME_RES + 4) : BIT_W'(4);
    localparam logic [SMP_W-1:0] SMP_MAX = SMP_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN,
        DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               bck_q, bck_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               lrck_q, lrck_d;
    logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [OUT_RES-1:0] sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               ovf_q, ovf_d;

    logic               wrap;
    logic               fall;
    logic [BIT_W-1:0]   bit_nxt;
    logic               frame_start;
    logic               slot_hit;
    logic [DATA_RES-1:0] word;
    logic               accept;
    logic               active;
    logic               cap;
    logic               load;
    logic               drop;
    logic               unused_lsbs;

    // Only the top OUT_RES bits of the selected channel are forwarded.
    assign word        = (CHANNEL == 0) ? left_i : right_i;
    assign unused_lsbs = ^{left_i, right_i};

    // Bit-clock timing: divider wrap toggles BCK, falling BCK steps the slot.
    always_comb begin
        wrap        = (div_cnt_q == DIV_MAX);
        fall        = wrap & bck_q;
        bit_nxt     = (bit_cnt_q == BIT_MAX) ? '0 : bit_cnt_q + 1'b1;
        frame_start = fall & (bit_nxt == '0);
        slot_hit    = fall & (bit_nxt == SLOT);
        div_cnt_d   = wrap ? '0 : div_cnt_q + 1'b1;
        bck_d       = wrap ? ~bck_q : bck_q;
        bit_cnt_d   = fall ? bit_nxt : bit_cnt_q;
        lrck_d      = fall ? bit_nxt[BIT_W-1] : lrck_q;
    end

    // Free-running clock generator registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            bck_q     <= 1'b0;
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bck_q     <= bck_d;
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture FSM next state: DRAIN only exits once the block's last
    // sample has been handed over, so IDLE never holds a pending sample.
    always_comb begin
        state_d = state_q;
        accept  = valid_q & ready_i;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = SYNC;
            end
            SYNC: begin
                if (!en_i)            state_d = IDLE;
                else if (frame_start) state_d = RUN;
            end
            RUN: begin
                if (!en_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (accept && last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: load on free slot, drop and flag when the sink stalls.
    always_comb begin
        active    = ((state_q == RUN) || (state_q == DRAIN)) &&
                    (state_d != IDLE);
        cap       = slot_hit & active;
        load      = cap & (~valid_q | ready_i);
        drop      = cap & valid_q & ~ready_i;
        sample_d  = sample_q;
        valid_d   = valid_q & ~ready_i;
        last_d    = accept ? 1'b0 : last_q;
        smp_cnt_d = smp_cnt_q;
        ovf_d     = ovf_q;
        if (load) begin
            sample_d = word[DATA_RES-1 -: OUT_RES];
            valid_d  = 1'b1;
            last_d   = (smp_cnt_q == SMP_MAX);
            smp_cnt_d = (smp_cnt_q == SMP_MAX) ? '0 : smp_cnt_q + 1'b1;
        end
        if (state_q == IDLE) begin
            smp_cnt_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_cnt_q <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            smp_cnt_q <= smp_cnt_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bck_o      = bck_q;
    assign lrck_o     = lrck_q;
    assign sample_o   = sample_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign busy_o     = (state_q != IDLE);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: clock/frame timing model plus a sample scoreboard
// filled at capture slots and drained on each accepted handshake.
module tb_i2s_rx_ctrl;

    localparam int BCK_DIV   = 2;
    localparam int FRAME_RES = 32;
    localparam int DATA_RES  = 24;
    localparam int OUT_RES   = 16;
    localparam int N_SAMPLES = 4;
    localparam int CHANNEL   = 0;
    localparam int FRAME_CLK = 2 * FRAME_RES * 2 * BCK_DIV;
    localparam int SLOT_CLK  = (FRAME_RES + 4) * 2 * BCK_DIV;

    typedef struct packed {
        logic                l;
        logic [OUT_RES-1:0]  s;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic                bck;
    logic                lrck;
    logic [DATA_RES-1:0] left;
    logic [DATA_RES-1:0] right;
    logic [OUT_RES-1:0]  sample;
    logic                valid;
    logic                ready;
    logic                last;
    logic                busy;
    logic                ovf;
    logic                clr_ovf;

    int          checks = 0;
    int          errors = 0;
    int unsigned k;
    int          vcyc = 0;
    int          accepted = 0;
    exp_t        sbq[$];

    i2s_rx_ctrl #(
        .BCK_DIV   (BCK_DIV),
        .FRAME_RES (FRAME_RES),
        .DATA_RES  (DATA_RES),
        .OUT_RES   (OUT_RES),
        .N_SAMPLES (N_SAMPLES),
        .CHANNEL   (CHANNEL)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .bck_o      (bck),
        .lrck_o     (lrck),
        .left_i     (left),
        .right_i    (right),
        .sample_o   (sample),
        .valid_o    (valid),
        .ready_i    (ready),
        .last_o     (last),
        .busy_o     (busy),
        .overflow_o (ovf),
        .clr_ovf_i  (clr_ovf)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the timing model is derived from this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic m_bck(input int unsigned kk);
        return ((kk / BCK_DIV) % 2) == 1;
    endfunction

    function automatic logic m_lrck(input int unsigned kk);
        return ((kk / (2 * BCK_DIV)) % (2 * FRAME_RES)) >= FRAME_RES;
    endfunction

    function automatic int unsigned next_frame(input int unsigned kk);
        return ((kk + 1) / FRAME_CLK + 1) * FRAME_CLK;
    endfunction

    // Handshake monitor: each accepted sample must match the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (valid) vcyc++;
            if (valid && ready) begin
                exp_t e;
                accepted++;
                chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("sample", 32'(sample), 32'(e.s));
                    chk("last", 32'(last), 32'(e.l));
                end
            end
        end
    end

    task automatic wait_k(input int unsigned t);
        int n = 0;
        while (k != t) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                $display("FAIL wait_k timeout got=%0d exp=%0d", k, t);
                $fatal(1);
            end
        end
    endtask

    // Present a word ahead of the capture edge c and predict its outcome.
    task automatic cap(input int unsigned c, input logic [DATA_RES-1:0] w,
                       input bit push, input bit l);
        wait_k(c - 1);
        left = w;
        if (push) sbq.push_back({l, w[DATA_RES-1 -: OUT_RES]});
    endtask

    initial begin
        int unsigned f;
        int unsigned c;
        int          v0;
        logic [DATA_RES-1:0] w;
        logic [DATA_RES-1:0] w10;

        rst_n   = 1'b0;
        en      = 1'b0;
        ready   = 1'b1;
        clr_ovf = 1'b0;
        left    = '0;
        right   = 24'h123456;

        // Reset state.
        repeat (5) @(negedge clk);
        chk("rst_bck", 32'(bck), 32'd0);
        chk("rst_lrck", 32'(lrck), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        rst_n = 1'b1;

        // Clock generation against the timing model.
        repeat (600) begin
            @(negedge clk);
            chk("bck", 32'(bck), 32'(m_bck(k)));
            chk("lrck", 32'(lrck), 32'(m_lrck(k)));
            chk("idle_valid", 32'(valid), 32'd0);
        end

        // Capture, truncation, latency and block framing.
        v0 = vcyc;
        en = 1'b1;
        f  = next_frame(k);
        for (int j = 0; j < 10; j++) begin
            c = f + SLOT_CLK + FRAME_CLK * j;
            w = (j == 0) ? 24'hABCDEF : 24'($urandom);
            cap(c, w, 1'b1, (j % N_SAMPLES) == N_SAMPLES - 1);
            chk("busy_run", 32'(busy), 32'd1);
            if (j == 0) begin
                chk("pre_valid", 32'(valid), 32'd0);
                @(negedge clk);
                chk("lat_valid", 32'(valid), 32'd1);
                chk("lat_sample", 32'(sample), 32'hABCD);
                @(negedge clk);
                chk("one_cycle", 32'(valid), 32'd0);
            end
        end
        wait_k(f + SLOT_CLK + FRAME_CLK * 9 + 2);
        chk("valid_cycles", 32'(vcyc - v0), 32'd10);
        chk("accepted", 32'(accepted), 32'd10);

        // Stall across two slots: hold first, drop second.
        c   = f + SLOT_CLK + FRAME_CLK * 10;
        w10 = 24'($urandom);
        cap(c, w10, 1'b1, 1'b0);
        ready = 1'b0;
        wait_k(c + 5);
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_ovf0", 32'(ovf), 32'd0);
        c = f + SLOT_CLK + FRAME_CLK * 11;
        cap(c, 24'($urandom), 1'b0, 1'b0);
        wait_k(c);
        chk("drop_ovf", 32'(ovf), 32'd1);
        chk("hold_sample", 32'(sample), 32'(w10[DATA_RES-1 -: OUT_RES]));
        chk("hold_last", 32'(last), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        chk("acc_clear", 32'(valid), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Counter held through the drop, so this closes the block.
        cap(f + SLOT_CLK + FRAME_CLK * 12, 24'($urandom), 1'b1, 1'b1);
        cap(f + SLOT_CLK + FRAME_CLK * 13, 24'($urandom), 1'b1, 1'b0);
        cap(f + SLOT_CLK + FRAME_CLK * 14, 24'($urandom), 1'b1, 1'b0);
        wait_k(f + SLOT_CLK + FRAME_CLK * 14 + 4);
        en = 1'b0;

        // Drain finishes the block, then returns to idle.
        cap(f + SLOT_CLK + FRAME_CLK * 15, 24'($urandom), 1'b1, 1'b0);
        chk("busy_drain", 32'(busy), 32'd1);
        c = f + SLOT_CLK + FRAME_CLK * 16;
        cap(c, 24'($urandom), 1'b1, 1'b1);
        wait_k(c + 2);
        chk("drain_idle", 32'(busy), 32'd0);
        chk("drain_valid", 32'(valid), 32'd0);
        v0 = vcyc;
        cap(f + SLOT_CLK + FRAME_CLK * 17, 24'($urandom), 1'b0, 1'b0);
        wait_k(f + SLOT_CLK + FRAME_CLK * 18 + 4);
        chk("no_more_valid", 32'(vcyc - v0), 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Asynchronous reset with a pending sample, then a fresh block.
        en    = 1'b1;
        ready = 1'b0;
        f     = next_frame(k);
        c     = f + SLOT_CLK;
        cap(c, 24'($urandom), 1'b1, 1'b0);
        wait_k(c + 20);
        chk("pend_valid", 32'(valid), 32'd1);
        chk("pend_lrck", 32'(lrck), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_bck", 32'(bck), 32'd0);
        chk("arst_lrck", 32'(lrck), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        ready = 1'b1;
        rst_n = 1'b1;
        f     = next_frame(k);
        for (int j = 0; j < 5; j++) begin
            cap(f + SLOT_CLK + FRAME_CLK * j, 24'($urandom), 1'b1,
                j == N_SAMPLES - 1);
        end
        wait_k(f + SLOT_CLK + FRAME_CLK * 4 + 3);
        chk("sb_final", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_ctrl.md
Name: i2s_rx_ctrl

Overview:
- Master-side controller for the I2S receive path.
- Generates BCK/LRCK for the external microphone and the I2S receiver from the system clock.
- Captures the selected channel word from the receiver outputs at a fixed safe bit slot, truncates it, and streams it to the FFT input buffer over a valid/ready handshake.
- Groups samples into blocks of N_SAMPLES, with start/stop gated on frame and block boundaries.

Parameters:
- BCK_DIV, 4: half-period of bck_o in clk_i cycles; bck = f_clk/(2*BCK_DIV); must be ≥1.
- FRAME_RES, 32: BCK cycles per channel half-frame.
- DATA_RES, 24: receiver word width.
- OUT_RES, 16: output sample width; must be ≤ DATA_RES.
- N_SAMPLES, 256: samples per FFT block; must be ≥2.
- CHANNEL, 0: 0 = left, 1 = right.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  async active-low reset
- en_i  in  1  capture enable (level)
- bck_o  out  1  I2S bit clock to mic and receiver
- lrck_o  out  1  I2S word select; 0 = left half
- left_i  in  DATA_RES  receiver left word
- right_i  in  DATA_RES  receiver right word
- sample_o  out  OUT_RES  output sample, left_i/right_i[DATA_RES-1 -: OUT_RES]
- valid_o  out  1  sample_o valid
- ready_i  in  1  sink ready
- last_o  out  1  qualifies final sample of block
- busy_o  out  1  state != IDLE
- overflow_o  out  1  sticky: sample dropped
- clr_ovf_i  in  1  synchronous clear of overflow_o

Behaviour:
- Reset: asynchronous on rst_ni low. All outputs 0, div_cnt = 0, bit_cnt = 0, smp_cnt = 0, state = IDLE.
- Clock generation (free-running after reset, independent of en_i):
  - div_cnt counts 0..BCK_DIV-1 and wraps.
  - bck_o toggles on every wrap.
  - A "fall event" is a wrap cycle in which bck_o is 1 (bck_o becomes 0).
- Bit counter: bit_cnt (log2(2*FRAME_RES) bits) increments on each fall event and wraps 2*FRAME_RES-1 → 0.
- lrck_o is registered and equals the next bit_cnt MSB, so it changes only at fall events.
- Frame start: fall event where bit_cnt wraps to 0 (lrck_o goes 1 → 0).
- Capture slots:
  - CHANNEL=0: fall event where new bit_cnt == FRAME_RES+4; capture left_i.
  - CHANNEL=1: fall event where new bit_cnt == 4; capture right_i.
  - The receiver word is stable at these slots; no resynchronisation is applied.
- FSM states:
  - IDLE: smp_cnt = 0, no captures. en_i = 1 → SYNC.
  - SYNC: wait for frame start → RUN. en_i = 0 in SYNC → IDLE.
  - RUN: each capture slot produces one sample. en_i = 0 → DRAIN.
  - DRAIN: identical to RUN, but when the sample with last_o = 1 is accepted (valid_o & ready_i) → IDLE.
  - RUN on accept of a last sample stays in RUN; the next block starts seamlessly.
- Output handshake:
  - On a capture, if !valid_o or (valid_o & ready_i) in that cycle, load sample_o, set valid_o, and set last_o = (smp_cnt == N_SAMPLES-1).
  - smp_cnt increments on load and wraps N_SAMPLES-1 → 0.
  - Latency: capture-slot fall event → valid_o 1 clk later.
  - While valid_o & !ready_i, sample_o and last_o are held.
  - valid_o clears on accept unless a new load occurs in the same cycle.
- Overflow: capture while valid_o & !ready_i → sample dropped, smp_cnt unchanged, overflow_o = 1.
  - overflow_o is sticky until clr_ovf_i.
  - Simultaneous set and clr_ovf_i → set wins.
- Capture slot coinciding with a transition to IDLE: capture is not taken.
- Pending valid_o on entry to IDLE is impossible by construction: exit from DRAIN requires acceptance.
- Reset mid-block: everything is cleared immediately and the partial block is discarded. The sink must treat reset as a block abort.

Test Plan:
1. BCK_DIV=2, reset release → bck_o period 4 clk; lrck_o period 256 clk; lrck_o changes only in cycles where bck_o falls; all outputs 0 during reset.
2. en_i=1, ready_i=1, left_i=24'hABCDEF, CHANNEL=0 → first valid_o 1 clk after the slot-36 fall event of the first full frame; sample_o=16'hABCD; exactly one valid cycle per 256 clk.
3. N_SAMPLES=4, ready_i=1 for 10 samples → last_o on samples 4 and 8 only; busy_o=1 throughout.
4. ready_i held 0 across two capture slots → first sample held stable, second dropped, overflow_o=1; smp_cnt does not advance; after clr_ovf_i pulse, overflow_o=0.
5. en_i dropped after sample 2 of a 4-sample block → samples 3 and 4 delivered; state returns to IDLE on acceptance of the last_o sample; no further valid_o.
6. rst_ni asserted mid-frame with valid_o=1 → valid_o, bck_o, lrck_o go 0 asynchronously; after release with en_i=1, the first sample has smp_cnt=0 and the first block's last_o comes after exactly N_SAMPLES samples.
